// File: rtl/inst_packer_pkg.sv
// Shared ISA definitions: opcode map, instruction formats, field positions
// and the packer FSM state type.
package inst_packer_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned MODE_W   = 2;
    localparam int unsigned JOFF_W   = 26;

    localparam int unsigned OP_LSB   = 26;
    localparam int unsigned RD_LSB   = 22;
    localparam int unsigned RS1_LSB  = 18;
    localparam int unsigned RS2_LSB  = 14;
    localparam int unsigned IMM_LSB  = 2;
    localparam int unsigned MODE_LSB = 0;

    localparam logic [OP_W-1:0] OP_AND  = 6'd0;
    localparam logic [OP_W-1:0] OP_OR   = 6'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 6'd2;
    localparam logic [OP_W-1:0] OP_ADDI = 6'd3;
    localparam logic [OP_W-1:0] OP_SUBI = 6'd4;
    localparam logic [OP_W-1:0] OP_ANDI = 6'd5;
    localparam logic [OP_W-1:0] OP_ORI  = 6'd6;
    localparam logic [OP_W-1:0] OP_XORI = 6'd7;
    localparam logic [OP_W-1:0] OP_LD   = 6'd8;
    localparam logic [OP_W-1:0] OP_ST   = 6'd9;
    localparam logic [OP_W-1:0] OP_SLLI = 6'd10;
    localparam logic [OP_W-1:0] OP_SRLI = 6'd11;
    localparam logic [OP_W-1:0] OP_JMP  = 6'd12;
    localparam logic [OP_W-1:0] OP_JAL  = 6'd13;
    localparam logic [OP_W-1:0] OP_RET  = 6'd14;
    localparam logic [OP_W-1:0] OP_PUSH = 6'd15;
    localparam logic [OP_W-1:0] OP_POP  = 6'd16;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_J, FMT_RET, FMT_S, FMT_ILLEGAL
    } fmt_t;

    typedef enum logic [1:0] {
        S_IDLE, S_ACCEPT, S_WRITE, S_DONE
    } state_t;

    function automatic fmt_t decode_fmt(input logic [OP_W-1:0] op);
        fmt_t f;
        case (op)
            OP_AND, OP_OR, OP_XOR:                      f = FMT_R;
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI,
            OP_LD, OP_ST, OP_SLLI, OP_SRLI:             f = FMT_I;
            OP_JMP, OP_JAL:                             f = FMT_J;
            OP_RET:                                     f = FMT_RET;
            OP_PUSH, OP_POP:                            f = FMT_S;
            default:                                    f = FMT_ILLEGAL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/inst_packer_if.sv
// Field-tuple stream into the packer and instruction-memory write port out of it.
interface inst_packer_if #(parameter int unsigned ADDR_W = 8);
    import inst_packer_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [OP_W-1:0]     op_code;
    logic [REG_W-1:0]    inst_rd;
    logic [REG_W-1:0]    inst_rs1;
    logic [REG_W-1:0]    inst_rs2;
    logic [IMM_W-1:0]    imm_16;
    logic [MODE_W-1:0]   mode;
    logic [JOFF_W-1:0]   jump_offset;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_wdata;

    modport master (
        output in_valid, op_code, inst_rd, inst_rs1, inst_rs2, imm_16, mode, jump_offset,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, op_code, inst_rd, inst_rs1, inst_rs2, imm_16, mode, jump_offset,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/inst_format_pack.sv
// Combinational instruction encoder: places only the fields each format uses,
// leaving every other bit zero, and flags opcodes outside the ISA.
module inst_format_pack
    import inst_packer_pkg::*;
(
    input  logic [OP_W-1:0]   op_code,
    input  logic [REG_W-1:0]  inst_rd,
    input  logic [REG_W-1:0]  inst_rs1,
    input  logic [REG_W-1:0]  inst_rs2,
    input  logic [IMM_W-1:0]  imm_16,
    input  logic [MODE_W-1:0] mode,
    input  logic [JOFF_W-1:0] jump_offset,
    output logic [31:0]       word,
    output logic              illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        word[OP_LSB +: OP_W] = op_code;
        case (decode_fmt(op_code))
            FMT_R: begin
                word[RD_LSB  +: REG_W] = inst_rd;
                word[RS1_LSB +: REG_W] = inst_rs1;
                word[RS2_LSB +: REG_W] = inst_rs2;
            end
            FMT_I: begin
                word[RD_LSB   +: REG_W]  = inst_rd;
                word[RS1_LSB  +: REG_W]  = inst_rs1;
                word[IMM_LSB  +: IMM_W]  = imm_16;
                word[MODE_LSB +: MODE_W] = mode;
            end
            FMT_J:   word[0 +: JOFF_W] = jump_offset;
            FMT_RET: ;
            FMT_S:   word[RD_LSB +: REG_W] = inst_rd;
            default: begin
                word    = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_packer.sv
// Load-session controller: accepts field tuples, packs legal instructions and
// writes them to consecutive instruction-memory words, one write per 2 cycles.
module inst_packer
    import inst_packer_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    inst_packer_if.slave      bus,
    output logic              busy,
    output logic              done,
    output logic              err_illegal
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, rem_q;
    logic [31:0]       word_q, pack_word;
    logic              pack_illegal, hs;

    inst_format_pack u_pack (
        .op_code     (bus.op_code),
        .inst_rd     (bus.inst_rd),
        .inst_rs1    (bus.inst_rs1),
        .inst_rs2    (bus.inst_rs2),
        .imm_16      (bus.imm_16),
        .mode        (bus.mode),
        .jump_offset (bus.jump_offset),
        .word        (pack_word),
        .illegal     (pack_illegal)
    );

    assign hs = bus.in_valid && (state_q == S_ACCEPT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = (count == '0) ? S_DONE : S_ACCEPT;
            S_ACCEPT: if (hs && !pack_illegal) state_d = S_WRITE;
            S_WRITE:  state_d = (rem_q == ADDR_W'(1)) ? S_DONE : S_ACCEPT;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == S_ACCEPT);
        bus.mem_we    = (state_q == S_WRITE);
        bus.mem_addr  = addr_q;
        bus.mem_wdata = word_q;
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
    end

    // Illegal opcodes are consumed in ACCEPT but leave address, count and word untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            rem_q       <= '0;
            word_q      <= '0;
            err_illegal <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    addr_q      <= base_addr;
                    rem_q       <= count;
                    err_illegal <= 1'b0;
                end
                S_ACCEPT: if (hs) begin
                    if (pack_illegal) err_illegal <= 1'b1;
                    else              word_q      <= pack_word;
                end
                S_WRITE: begin
                    addr_q <= addr_q + ADDR_W'(1);
                    rem_q  <= rem_q - ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_packer.sv
// Directed bench for inst_packer: expected writes come from a format-rule model
// queued per session; a negedge monitor checks every memory write against it.
module tb_inst_packer;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] count = '0;
    logic          busy, done, err_illegal;

    inst_packer_if #(.ADDR_W(AW)) bus ();

    inst_packer #(.ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .count       (count),
        .bus         (bus.slave),
        .busy        (busy),
        .done        (done),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    int            vectors = 0;
    int            miscompares = 0;
    logic [39:0]   exp_q[$];
    logic [AW-1:0] model_addr = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Returns {illegal, word} from the opcode-range rules of the ISA.
    function automatic logic [32:0] model_pack(input int unsigned op, rd, rs1, rs2, imm, mode, off);
        int unsigned w;
        w = op << 26;
        if (op <= 2)       w = w | (rd << 22) | (rs1 << 18) | (rs2 << 14);
        else if (op <= 11) w = w | (rd << 22) | (rs1 << 18) | (imm << 2) | mode;
        else if (op <= 13) w = w | off;
        else if (op == 14) w = w;
        else if (op <= 16) w = w | (rd << 22);
        else               return {1'b1, 32'h0};
        return {1'b0, w};
    endfunction

    always @(negedge clk) begin
        if (bus.mem_we) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: mem_we=1 addr 0x%02h data 0x%08h, expected no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                check("write_addr", 32'(bus.mem_addr), 32'(e[39:32]));
                check("write_data", bus.mem_wdata, e[31:0]);
            end
        end
    end

    task automatic scramble_fields();
        bus.op_code     = 6'($urandom);
        bus.inst_rd     = 4'($urandom);
        bus.inst_rs1    = 4'($urandom);
        bus.inst_rs2    = 4'($urandom);
        bus.imm_16      = 16'($urandom);
        bus.mode        = 2'($urandom);
        bus.jump_offset = 26'($urandom);
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] c);
        @(negedge clk);
        base_addr  = b;
        count      = c;
        start      = 1'b1;
        model_addr = b;
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        count     = AW'($urandom);
    endtask

    task automatic send(input int unsigned op, rd, rs1, rs2, imm, mode, off);
        logic [32:0] r;
        bit          rdy = 1'b0;
        r = model_pack(op, rd, rs1, rs2, imm, mode, off);
        for (int i = 0; i < 50 && !rdy; i++) begin
            @(negedge clk);
            rdy = bus.in_ready;
        end
        if (!rdy) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_timeout: in_ready=0 for 50 cycles, expected 1");
        end else begin
            if (!r[32]) begin
                exp_q.push_back({model_addr, r[31:0]});
                model_addr = model_addr + AW'(1);
            end
            bus.op_code     = 6'(op);
            bus.inst_rd     = 4'(rd);
            bus.inst_rs1    = 4'(rs1);
            bus.inst_rs2    = 4'(rs2);
            bus.imm_16      = 16'(imm);
            bus.mode        = 2'(mode);
            bus.jump_offset = 26'(off);
            bus.in_valid    = 1'b1;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            scramble_fields();
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        scramble_fields();

        // Model pinned to hand-encoded words.
        check("pin_r",   model_pack(1, 3, 4, 5, 16'hFFFF, 3, 26'h3FFFFFF), {1'b0, 32'h04D14000});
        check("pin_i",   model_pack(3, 1, 2, 9, 16'hABCD, 2, 26'h3FFFFFF), {1'b0, 32'h0C4AAF36});
        check("pin_j",   model_pack(12, 15, 15, 15, 16'hFFFF, 3, 26'h123456), {1'b0, 32'h30123456});
        check("pin_ret", model_pack(14, 15, 15, 15, 16'hFFFF, 3, 26'h3FFFFFF), {1'b0, 32'h38000000});
        check("pin_s",   model_pack(15, 7, 15, 15, 16'hFFFF, 3, 26'h3FFFFFF), {1'b0, 32'h3DC00000});
        check("pin_ill", 32'(model_pack(20, 0, 0, 0, 0, 0, 0) >> 32), 32'd1);

        #22;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mem_we",   32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wdata",    bus.mem_wdata, 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_done",     32'(done), 32'd0);
        check("rst_err",      32'(err_illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single R-type word.
        do_start(8'h10, 8'd1);
        @(negedge clk);
        check("s1_in_ready", 32'(bus.in_ready), 32'd1);
        check("s1_busy", 32'(busy), 32'd1);
        send(1, 3, 4, 5, $urandom, $urandom, $urandom);
        wait_done("s1");

        // I / J / RET back to back, junk in unused fields.
        do_start(8'h20, 8'd3);
        send(3, 1, 2, 4'hF, 16'hABCD, 2, 26'h3FFFFFF);
        send(12, 4'hF, 4'hF, 4'hF, 16'hFFFF, 3, 26'h123456);
        send(14, 4'hF, 4'hF, 4'hF, 16'hFFFF, 3, 26'h3FFFFFF);
        wait_done("s2");

        // Illegal opcode mid-session, then sticky flag, then cleared by start.
        do_start(8'h50, 8'd2);
        check("s3_err_clear", 32'(err_illegal), 32'd0);
        send(5, 6, 7, 8, 16'h1234, 1, $urandom);
        send(20, 1, 1, 1, 16'h1111, 1, 26'h1111);
        @(negedge clk);
        check("s3_err_set", 32'(err_illegal), 32'd1);
        check("s3_stay_accept", 32'(bus.in_ready), 32'd1);
        check("s3_no_we", 32'(bus.mem_we), 32'd0);
        send(13, 0, 0, 0, 0, 0, 26'h2ABCDEF);
        wait_done("s3");
        check("s3_err_sticky", 32'(err_illegal), 32'd1);

        // count==0: done right after start, no writes; also clears err.
        do_start(8'h30, 8'd0);
        @(negedge clk);
        check("s4_done", 32'(done), 32'd1);
        check("s4_no_we", 32'(bus.mem_we), 32'd0);
        check("s4_err_clr", 32'(err_illegal), 32'd0);
        @(negedge clk);
        check("s4_done_pulse", 32'(done), 32'd0);
        check("s4_idle", 32'(busy), 32'd0);

        // Address wrap.
        do_start(8'hFF, 8'd2);
        send(0, 9, 10, 11, $urandom, $urandom, $urandom);
        send(16, 12, 3, 3, $urandom, $urandom, $urandom);
        wait_done("s5");

        // start while busy is ignored.
        do_start(8'h20, 8'd2);
        send(15, 2, 0, 0, $urandom, $urandom, $urandom);
        @(negedge clk);
        base_addr = 8'h80;
        count     = 8'd0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send(11, 4, 5, 6, 16'h0F0F, 3, $urandom);
        wait_done("s6");

        // Reset during WRITE.
        do_start(8'h40, 8'd2);
        send(2, 1, 2, 3, $urandom, $urandom, $urandom);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("r_mem_we",   32'(bus.mem_we), 32'd0);
        check("r_busy",     32'(busy), 32'd0);
        check("r_in_ready", 32'(bus.in_ready), 32'd0);
        check("r_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("r_wdata",    bus.mem_wdata, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus.op_code  = 6'd1;
        bus.in_valid = 1'b1;
        repeat (10) @(negedge clk);
        check("r_busy_after", 32'(busy), 32'd0);
        bus.in_valid = 1'b0;

        // Normal operation after reset.
        do_start(8'h00, 8'd1);
        send(16, 9, $urandom, $urandom, $urandom, $urandom, $urandom);
        wait_done("s7");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
